i2c_clk_gen: RTL

I2C_CLK_GEN -- requirements
Module: i2c_clk_gen

---
 rtl/i2c_clk_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/i2c_clk_gen.sv
// ---------------------------------------------------------------------------
// i2c_clk_gen -- I2C master SCL generator with quarter-period timing strobes.
//
// One SCL period is four quarters (P0, P1 low; P2, P3 high). Each quarter
// lasts div_q+1 clk cycles. A registered strobe marks the first cycle of
// each quarter, so a byte engine can change SDA mid-low and sample it
// mid-high. A slave may stretch the clock by holding the sensed SCL low
// during the high phase; the generator then freezes in P2 until SCL is
// released.
//
// Ports
//   clk         system clock, rising-edge
//   rst_n       asynchronous active-low reset
//   en          run request (level); deassertion finishes the current period
//   div_val     new quarter-period divisor
//   div_load    strobe: capture div_val into the shadow register
//   scl_in      synchronised bus SCL, used for clock stretching
//   stretch_en  allow a slave to stretch the high phase
//   scl_out     generated SCL (registered)
//   fall_stb    first cycle of P0 (SCL fell)
//   chg_stb     first cycle of P1 (SDA change point)
//   rise_stb    first cycle of P2 (SCL rose)
//   smp_stb     first cycle of P3 (SDA sample point)
//   busy        generator is not idle
//   stretched   stretch hold currently active
// ---------------------------------------------------------------------------
module i2c_clk_gen #(
   parameter int DIV_W     = 8,
   parameter int RESET_DIV = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   input  logic             scl_in,
   input  logic             stretch_en,
   output logic             scl_out,
   output logic             fall_stb,
   output logic             chg_stb,
   output logic             rise_stb,
   output logic             smp_stb,
   output logic             busy,
   output logic             stretched
);

   typedef enum logic [2:0] {
      IDLE,
      P0,   // low, first quarter
      P1,   // low, second quarter
      P2,   // high, first quarter (stretchable)
      P3    // high, second quarter
   } state_t;

   localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] div_q;    // divisor in use for the current quarter
   logic [DIV_W-1:0] shadow;   // divisor waiting for the next quarter boundary
   logic             hold;
   logic             terminal;
   logic             advance;
   logic             entering;

   // A slave holding SCL low while we drive it high freezes the high phase.
   assign hold      = (state == P2) && stretch_en && !scl_in;
   assign terminal  = (cnt == div_q);
   assign stretched = hold;
   assign busy      = (state != IDLE);
   assign entering  = (state_nxt != state);

   // NOTE: every output of a combinational block gets a default before any
   // branch; a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      advance   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (en) state_nxt = P0;
         end
         default: begin
            if (!hold) begin
               if (terminal) begin
                  cnt_nxt = '0;
                  advance = 1'b1;
                  case (state)
                     P0:      state_nxt = P1;
                     P1:      state_nxt = P2;
                     P2:      state_nxt = P3;
                     P3:      state_nxt = en ? P0 : IDLE;
                     default: state_nxt = IDLE;
                  endcase
               end else begin
                  cnt_nxt = cnt + DIV_W'(1);
               end
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         div_q    <= RESET_DIV_V;
         shadow   <= RESET_DIV_V;
         scl_out  <= 1'b1;
         fall_stb <= 1'b0;
         chg_stb  <= 1'b0;
         rise_stb <= 1'b0;
         smp_stb  <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (div_load) shadow <= div_val;
         // The divisor only changes between quarters, so no quarter mixes
         // two divisors; a load on a boundary waits for the next boundary.
         if (state == IDLE || advance) div_q <= shadow;
         scl_out  <= !(state_nxt == P0 || state_nxt == P1);
         fall_stb <= entering && (state_nxt == P0);
         chg_stb  <= entering && (state_nxt == P1);
         rise_stb <= entering && (state_nxt == P2);
         smp_stb  <= entering && (state_nxt == P3);
      end
   end

endmodule
